uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side byte buffer between the UART receiver and the RX read stage. It captures each byte the receiver completes and holds bytes in order. It presents the oldest byte in first-word-fall-through form on `uart_rx_data`/`uart_rx_empty`, and pops it when the read stage asserts `uart_rx_ena`. It also reports fill level and flags any bytes lost to overflow.

## Interface
- `DATA_W`, default 8: byte width.
- `ADDR_W`, default 4: log2 of depth, so depth = 2^ADDR_W = 16 entries.

- `ckht`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_data`  in  DATA_W  byte from the receiver.
- `wr_ena`  in  1  one-cycle strobe: `wr_data` is valid this cycle.
- `uart_rx_ena`  in  1  pop request from the read stage.
- `clr_ovf`  in  1  synchronous clear of `overflow`.
- `uart_rx_data`  out  DATA_W  head-of-queue byte, valid whenever `uart_rx_empty`=0.
- `uart_rx_empty`  out  1  queue holds no bytes.
- `full`  out  1  queue holds 2^ADDR_W bytes.
- `level`  out  ADDR_W+1  number of bytes held, 0..2^ADDR_W.
- `overflow`  out  1  sticky flag: at least one byte was dropped.

## Operation
- Storage is a 2^ADDR_W × DATA_W register array. It is not reset.
- Pointers:
  - `wr_ptr` and `rd_ptr` are each ADDR_W+1 bits; the MSB is a wrap bit.
  - `uart_rx_empty` is asserted when the two pointers are equal.
  - `full` is asserted when the low bits are equal and the MSBs differ.
  - Both pointers wrap naturally modulo 2^(ADDR_W+1).
- Read accept: `rd_acc` = `uart_rx_ena` & ~`uart_rx_empty`. On accept, `rd_ptr` increments. A pop while empty is ignored; nothing changes.
- Write accept: `wr_acc` = `wr_ena` & (~`full` | `rd_acc`). On accept, `mem[wr_ptr]` ← `wr_data` and `wr_ptr` increments.
  - When the queue is full and a pop happens in the same cycle, the write is accepted.
- Drop: if `wr_ena` & ~`wr_acc`, the byte is discarded, the pointers are unchanged, and `overflow` is set.
- `level` is `wr_ptr` − `rd_ptr` taken modulo 2^(ADDR_W+1). It is registered, or derived from the registered pointers.
- `uart_rx_data`:
  - Equals `mem[rd_ptr[ADDR_W-1:0]]` when not empty.
  - Forced to 0 when empty.
- `overflow`:
  - Set by a drop and cleared by `clr_ovf`.
  - If a drop and `clr_ovf` occur in the same cycle, set wins.
- Simultaneous write and pop when `level` is between 1 and 2^ADDR_W−1: both are accepted and `level` is unchanged.
- Simultaneous write and pop when empty: the write is accepted and the pop is ignored, so `level` becomes 1.
- Reset (asserted asynchronously, including mid-operation):
  - Pointers go to 0 and `overflow` goes to 0.
  - Outputs become `uart_rx_empty`=1, `full`=0, `level`=0, `uart_rx_data`=0, `overflow`=0.
  - All contents are considered lost.
- Reset release is synchronous to `ckht`. The first write may occur on the first edge after `rst_n` rises.

## Timing
- Write-to-visible latency is 1 cycle. After a write to an empty queue at edge k, the following hold after edge k:
  - `uart_rx_empty`=0.
  - `uart_rx_data` = the written byte.
  - `level`=1.
- Pop latency is 1 cycle: `uart_rx_ena` sampled at edge k advances the head after edge k.
  - The read stage may therefore sample `uart_rx_data` in the same cycle it asserts `uart_rx_ena`, and register that byte at edge k.
- Back-to-back pops are allowed every cycle. Back-to-back writes are allowed every cycle.
- `full`, `uart_rx_empty`, `level` and `overflow` all change only on `ckht` edges or on asynchronous reset. They must not combinationally depend on `wr_ena` or `uart_rx_ena`.
- `uart_rx_data` depends only on registered state, with no input-to-output combinational path.

## Test plan
- Reset check: assert `rst_n`=0 mid-stream after 5 writes, then release. Required: `uart_rx_empty`=1, `level`=0, `uart_rx_data`=0x00, `overflow`=0. The next write of 0x41 appears on `uart_rx_data` one cycle later.
- Ordered transfer: write 0x11, 0x22, 0x33 on consecutive cycles, then pop 3 times back-to-back. Required: the head reads 0x11, 0x22, 0x33 in order, `level` goes 3→2→1→0, and `uart_rx_empty`=1 after the third pop.
- Fill, wrap and full: write 16 bytes 0x00..0x0F. Required: `full`=1, `level`=16. Pop 8, write 8 more (0x10..0x17), then drain. Required: the output sequence is 0x00..0x17 contiguous across the pointer wrap.
- Overflow: with the queue full, write 0xAA without a pop. Required: the byte is dropped, `overflow`=1, `level`=16, and the head is unchanged. Then assert `clr_ovf` together with another dropped write. Required: `overflow` stays 1. Then assert `clr_ovf` alone. Required: `overflow`=0.
- Full plus simultaneous pop and write: with the queue full, pop and write 0x5A in the same cycle. Required: accepted, `level` stays 16, `overflow` stays 0, and 0x5A emerges last on drain.
- Empty edge cases:
  - Pop while empty. Required: no change.
  - Write 0x77 and pop in the same cycle while empty. Required: `level`=1 and `uart_rx_data`=0x77 on the next cycle.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive-side byte queue between the UART receiver and the RX read stage.
// First-word-fall-through head, registered fill level, sticky overflow flag.
module uart_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              ckht,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_ena,
    input  logic              uart_rx_ena,
    input  logic              clr_ovf,
    output logic [DATA_W-1:0] uart_rx_data,
    output logic              uart_rx_empty,
    output logic              full,
    output logic [ADDR_W:0]   level,
    output logic              overflow
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic              rd_acc;
    logic              wr_acc;
    logic              drop;

    assign uart_rx_empty = (wr_ptr == rd_ptr);
    assign full          = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                           (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    assign level         = wr_ptr - rd_ptr;

    assign rd_acc = uart_rx_ena & ~uart_rx_empty;
    // A pop in the same cycle frees a slot, so a full queue still takes the byte.
    assign wr_acc = wr_ena & (~full | rd_acc);
    assign drop   = wr_ena & ~wr_acc;

    assign uart_rx_data = uart_rx_empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];

    always_ff @(posedge ckht) begin
        if (wr_acc) begin
            mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge ckht or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Set has priority so a drop coinciding with a clear is never lost.
    always_ff @(posedge ckht or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_uart_rx_fifo;

    logic       ckht;
    logic       rst_n;
    logic [7:0] wr_data;
    logic       wr_ena;
    logic       uart_rx_ena;
    logic       clr_ovf;
    logic [7:0] uart_rx_data;
    logic       uart_rx_empty;
    logic       full;
    logic [4:0] level;
    logic       overflow;

    int total;
    int bad;

    uart_rx_fifo #(.DATA_W(8), .ADDR_W(4)) dut (
        .ckht          (ckht),
        .rst_n         (rst_n),
        .wr_data       (wr_data),
        .wr_ena        (wr_ena),
        .uart_rx_ena   (uart_rx_ena),
        .clr_ovf       (clr_ovf),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_empty (uart_rx_empty),
        .full          (full),
        .level         (level),
        .overflow      (overflow)
    );

    initial ckht = 1'b0;
    always #5 ckht = ~ckht;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ckht);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        wr_data = b;
        wr_ena  = 1'b1;
        tick();
        wr_ena  = 1'b0;
    endtask

    task automatic pop();
        uart_rx_ena = 1'b1;
        tick();
        uart_rx_ena = 1'b0;
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst_n       = 1'b0;
        wr_data     = '0;
        wr_ena      = 1'b0;
        uart_rx_ena = 1'b0;
        clr_ovf     = 1'b0;
        repeat (3) @(posedge ckht);
        @(negedge ckht);
        rst_n = 1'b1;
        #1;
        chk("rst_empty", uart_rx_empty, 1);
        chk("rst_full", full, 0);
        chk("rst_level", level, 0);
        chk("rst_data", uart_rx_data, 0);
        chk("rst_ovf", overflow, 0);

        // mid-stream asynchronous reset
        for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i));
        chk("pre_rst_level", level, 5);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_empty", uart_rx_empty, 1);
        chk("mrst_level", level, 0);
        chk("mrst_data", uart_rx_data, 0);
        chk("mrst_ovf", overflow, 0);
        @(negedge ckht);
        rst_n = 1'b1;
        push(8'h41);
        chk("post_rst_data", uart_rx_data, 8'h41);
        chk("post_rst_level", level, 1);
        pop();
        chk("post_rst_drain", uart_rx_empty, 1);

        // ordered transfer
        push(8'h11);
        push(8'h22);
        push(8'h33);
        chk("ord_level3", level, 3);
        chk("ord_head0", uart_rx_data, 8'h11);
        pop();
        chk("ord_head1", uart_rx_data, 8'h22);
        chk("ord_level2", level, 2);
        pop();
        chk("ord_head2", uart_rx_data, 8'h33);
        chk("ord_level1", level, 1);
        pop();
        chk("ord_level0", level, 0);
        chk("ord_empty", uart_rx_empty, 1);
        chk("ord_data0", uart_rx_data, 0);

        // fill, wrap, full
        for (int i = 0; i < 16; i++) push(8'(i));
        chk("fill_full", full, 1);
        chk("fill_level", level, 16);
        for (int i = 0; i < 8; i++) begin
            chk("wrap_head_a", uart_rx_data, i);
            pop();
        end
        chk("wrap_level8", level, 8);
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
        chk("wrap_full", full, 1);
        for (int i = 0; i < 16; i++) begin
            chk("wrap_head_b", uart_rx_data, 8 + i);
            pop();
        end
        chk("wrap_empty", uart_rx_empty, 1);

        // overflow
        for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
        push(8'hAA);
        chk("ovf_set", overflow, 1);
        chk("ovf_level", level, 16);
        chk("ovf_head", uart_rx_data, 8'h20);
        clr_ovf = 1'b1;
        push(8'hAB);
        clr_ovf = 1'b0;
        chk("ovf_set_wins", overflow, 1);
        chk("ovf_level2", level, 16);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("ovf_clr", overflow, 0);

        // full with simultaneous pop and write
        wr_data     = 8'h5A;
        wr_ena      = 1'b1;
        uart_rx_ena = 1'b1;
        tick();
        wr_ena      = 1'b0;
        uart_rx_ena = 1'b0;
        chk("fpw_level", level, 16);
        chk("fpw_full", full, 1);
        chk("fpw_ovf", overflow, 0);
        chk("fpw_head", uart_rx_data, 8'h21);
        for (int i = 0; i < 16; i++) begin
            chk("fpw_drain", uart_rx_data, (i < 15) ? 8'h21 + i : 8'h5A);
            pop();
        end
        chk("fpw_empty", uart_rx_empty, 1);

        // empty edge cases
        pop();
        chk("epop_level", level, 0);
        chk("epop_empty", uart_rx_empty, 1);
        chk("epop_data", uart_rx_data, 0);
        chk("epop_ovf", overflow, 0);
        wr_data     = 8'h77;
        wr_ena      = 1'b1;
        uart_rx_ena = 1'b1;
        tick();
        wr_ena      = 1'b0;
        uart_rx_ena = 1'b0;
        chk("epw_level", level, 1);
        chk("epw_data", uart_rx_data, 8'h77);
        chk("epw_empty", uart_rx_empty, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
